// File: rtl/inj_pkg.sv
// Shared types and defaults for the external-instruction injector.
package inj_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    EXEC  = 2'd2
  } inj_state_t;

  localparam logic [3:0]  FETCH_STATE_DEF = 4'd0;
  localparam logic [31:0] NOP_WORD_DEF    = 32'h0000_0000;
  localparam int          DATA_W          = 32;

endpackage

// File: rtl/inj_fifo.sv
// Synchronous first-word-fall-through FIFO holding queued instruction words.
module inj_fifo
  import inj_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [DATA_W-1:0]        din,
  input  logic                     pop,
  output logic [DATA_W-1:0]        dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW:0]       wr_ptr;
  logic [AW:0]       rd_ptr;
  logic              push_ok;
  logic              pop_ok;

  // Pointers carry one extra bit so full and empty are distinguishable.
  assign count   = wr_ptr - rd_ptr;
  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign dout    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/inst_injector.sv
// Feeds queued instruction words to the multicycle core's extInst path, one per execution.
// Optional watchdog abandons a stuck word when INJ_WATCHDOG_EN is defined.
module inst_injector
  import inj_pkg::*;
#(
  parameter int          DEPTH       = 8,
  parameter logic [3:0]  FETCH_STATE = FETCH_STATE_DEF,
  parameter logic [31:0] NOP_WORD    = NOP_WORD_DEF,
  parameter int          WD_LIMIT    = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   inj_mode,
  input  logic                   in_valid,
  input  logic [31:0]            in_inst,
  output logic                   in_ready,
  input  logic [3:0]             core_state,
  output logic [31:0]            extInst,
  output logic                   extInst_en,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic                   busy,
  output logic [15:0]            retired,
  output logic                   drop,
  output logic                   wd_err
);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || WD_LIMIT < 1) begin : g_bad_param
    $error("inst_injector: DEPTH must be a power of two >= 2 and WD_LIMIT >= 1");
  end

  inj_state_t        state;
  logic [31:0]       hold;
  logic [31:0]       head;
  logic              full;
  logic              empty;
  logic              push;
  logic              pop;
  logic              at_fetch;
  logic              wd_fire;

  assign at_fetch   = (core_state == FETCH_STATE);
  assign in_ready   = !full;
  assign push       = in_valid && in_ready;
  assign extInst    = hold;
  assign extInst_en = inj_mode;
  assign busy       = (state != IDLE);

  inj_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (in_inst),
    .pop   (pop),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (fifo_count)
  );

  // A word is popped exactly when it is loaded into hold, from IDLE or on a back-to-back retire.
  always_comb begin
    pop = 1'b0;
    case (state)
      IDLE:    pop = inj_mode && !empty && at_fetch;
      EXEC:    pop = inj_mode && !empty && at_fetch;
      default: pop = 1'b0;
    endcase
  end

`ifdef INJ_WATCHDOG_EN
  localparam int WD_W = $clog2(WD_LIMIT) + 1;

  logic [WD_W-1:0] wd_cnt;
  logic            wd_expire;
  logic            wd_err_r;

  assign wd_expire = (wd_cnt == WD_W'(WD_LIMIT - 1));
  // A retiring word wins over a simultaneous expiry; mode loss wins over both.
  assign wd_fire   = inj_mode && wd_expire &&
                     ((state == ISSUE) || (state == EXEC && !at_fetch));
  assign wd_err    = wd_err_r;

  always_ff @(posedge clk) begin
    if (rst) begin
      wd_cnt   <= '0;
      wd_err_r <= 1'b0;
    end else begin
      wd_err_r <= wd_fire;
      if (pop)
        wd_cnt <= '0;
      else if (state != IDLE)
        wd_cnt <= wd_cnt + 1'b1;
    end
  end
`else
  assign wd_fire = 1'b0;
  assign wd_err  = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      hold    <= NOP_WORD;
      retired <= '0;
      drop    <= 1'b0;
    end else begin
      drop <= 1'b0;
      case (state)
        IDLE: begin
          if (pop) begin
            hold  <= head;
            state <= ISSUE;
          end else begin
            hold  <= NOP_WORD;
          end
        end
        ISSUE: begin
          if (!inj_mode || wd_fire) begin
            hold  <= NOP_WORD;
            drop  <= 1'b1;
            state <= IDLE;
          end else if (!at_fetch) begin
            state <= EXEC;
          end
        end
        EXEC: begin
          if (!inj_mode || wd_fire) begin
            hold  <= NOP_WORD;
            drop  <= 1'b1;
            state <= IDLE;
          end else if (at_fetch) begin
            retired <= retired + 16'd1;
            if (pop) begin
              hold  <= head;
              state <= ISSUE;
            end else begin
              hold  <= NOP_WORD;
              state <= IDLE;
            end
          end
        end
        default: begin
          hold  <= NOP_WORD;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
